// File: rtl/alu_issue_stage.sv
// Issue/writeback stage feeding a 2-bit-opcode combinational ALU, with a 4-entry register file.
// Optional macro ALU_ISSUE_FWD_EN: forward the writeback result into operand read instead of stalling.
module alu_issue_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_instr,
    input  logic             in_imm_en,
    input  logic [WIDTH-1:0] in_imm,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        OP_ADDU = 2'h0,
        OP_SUBU = 2'h1,
        OP_AND  = 2'h2,
        OP_XOR  = 2'h3
    } op_e;

    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       rd_q;
    logic             valid_q;
    logic [CNT_W-1:0] retire_q;

    // Entry 0 is reset to zero and never written, so it always reads zero.
    logic [WIDTH-1:0] rf [4];

    op_e              op_in;
    logic [1:0]       rd_in;
    logic [1:0]       rs_in;
    logic [1:0]       rt_in;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic             issue;
    logic             wb;

    assign op_in = op_e'(in_instr[7:6]);
    assign rd_in = in_instr[5:4];
    assign rs_in = in_instr[3:2];
    assign rt_in = in_instr[1:0];

    assign wb    = valid_q && alu_ready;
    assign issue = in_valid && in_ready;

`ifdef ALU_ISSUE_FWD_EN
    logic fwd_a;
    logic fwd_b;

    always_comb begin
        fwd_a    = wb && (rd_q != '0) && (rd_q == rs_in);
        fwd_b    = wb && (rd_q != '0) && (rd_q == rt_in);
        opnd_a   = fwd_a ? alu_result : rf[rs_in];
        opnd_b   = in_imm_en ? in_imm : (fwd_b ? alu_result : rf[rt_in]);
        in_ready = !valid_q || alu_ready;
    end
`else
    logic hazard;

    // Without forwarding, hold off a reader of the in-flight rd until it has written back.
    always_comb begin
        hazard   = valid_q && (rd_q != '0) &&
                   ((rd_q == rs_in) || (!in_imm_en && (rd_q == rt_in)));
        opnd_a   = rf[rs_in];
        opnd_b   = in_imm_en ? in_imm : rf[rt_in];
        in_ready = (!valid_q || alu_ready) && !hazard;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= OP_ADDU;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else if (issue) begin
            op_q    <= op_in;
            a_q     <= opnd_a;
            b_q     <= opnd_b;
            rd_q    <= rd_in;
            valid_q <= 1'b1;
        end else if (wb) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
            retire_q <= '0;
        end else if (wb) begin
            if (rd_q != '0) begin
                rf[rd_q] <= alu_result;
            end
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign alu_valid  = valid_q;
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign dbg_data   = rf[dbg_addr];
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: the bench acts as the ALU, keeps an in-order register
// model, and scoreboards the operands presented at each writeback.
module tb_alu_issue_stage;

    localparam int TB_CNT_W = 4;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [7:0]          in_instr = '0;
    logic                in_imm_en = 1'b0;
    logic [7:0]          in_imm = '0;
    logic                alu_valid;
    logic                alu_ready = 1'b1;
    logic [1:0]          alu_op;
    logic [7:0]          alu_a;
    logic [7:0]          alu_b;
    logic [7:0]          alu_result;
    logic [1:0]          dbg_addr = '0;
    logic [7:0]          dbg_data;
    logic [TB_CNT_W-1:0] retire_cnt;

    int errors = 0;
    int checks = 0;

    exp_t                sb[$];
    logic [7:0]          mrf [4];
    logic [TB_CNT_W-1:0] mcnt;

    alu_issue_stage #(.WIDTH(8), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_imm_en  (in_imm_en),
        .in_imm     (in_imm),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'h0:    return a + b;
            2'h1:    return a - b;
            2'h2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mrf[i] = '0;
        mcnt = '0;
        sb.delete();
    endtask

    // Drive one instruction from the negedge and hold it until accepted; report stall cycles.
    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic ie, input logic [7:0] imm,
                         output int stalls);
        logic rdy;
        logic done;
        exp_t e;
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = {op, rd, rs, rt};
        in_imm_en = ie;
        in_imm    = imm;
        stalls    = 0;
        done      = 1'b0;
        while (!done) begin
            #1 rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_timeout: in_ready held 0 for %0d cycles, required acceptance", stalls);
                    return;
                end
                @(negedge clk);
            end
        end
        e.op = op;
        e.a  = mrf[rs];
        e.b  = ie ? imm : mrf[rt];
        if (rd != 2'd0) mrf[rd] = alu_f(e.op, e.a, e.b);
        mcnt = mcnt + 1'b1;
        sb.push_back(e);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1 check(tag, {24'h0, dbg_data}, {24'h0, exp});
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 4; i++) check_reg(tag, 2'(i), mrf[i]);
    endtask

    // Writeback monitor: compare what the ALU sees against the scoreboard entry.
    always @(negedge clk) begin
        #2;
        if (reset_n && alu_valid && alu_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: writeback op=%0h a=%0h b=%0h, required none", alu_op, alu_a, alu_b);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_op", {30'h0, alu_op}, {30'h0, e.op});
                check("wb_a", {24'h0, alu_a}, {24'h0, e.a});
                check("wb_b", {24'h0, alu_b}, {24'h0, e.b});
            end
        end
    end

    initial begin
        int st;
        int exp_dep_stall;
`ifdef ALU_ISSUE_FWD_EN
        exp_dep_stall = 0;
`else
        exp_dep_stall = 1;
`endif
        model_reset();

        // Reset state
        #12;
        check("rst_alu_valid", {31'h0, alu_valid}, 32'h0);
        check("rst_alu_op", {30'h0, alu_op}, 32'h0);
        check("rst_alu_a", {24'h0, alu_a}, 32'h0);
        check("rst_alu_b", {24'h0, alu_b}, 32'h0);
        check("rst_retire", {28'h0, retire_cnt}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check_all_regs("rst_rf");

        // Load, dependent XOR back-to-back, wrap via SUBU
        issue(2'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, st);
        check("ld_stall", st, 0);
        issue(2'h3, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00, st);
        check("xor_dep_stall", st, exp_dep_stall);
        issue(2'h1, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01, st);
        check("subu_stall", st, 0);
        idle(3);
        check("retire_3", {28'h0, retire_cnt}, 32'd3);
        check_reg("rf1_05", 2'd1, 8'h05);
        check_reg("rf2_00", 2'd2, 8'h00);
        check_reg("rf3_ff", 2'd3, 8'hFF);

        // Writeback to R0 is dropped but counted
        issue(2'h0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h7F, st);
        idle(3);
        check_reg("r0_zero", 2'd0, 8'h00);
        check("retire_r0", {28'h0, retire_cnt}, 32'd4);

        // Backpressure: AND r2,r1,r3 held for three edges
        alu_ready = 1'b0;
        issue(2'h2, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00, st);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
            check("bp_op", {30'h0, alu_op}, 32'h2);
            check("bp_a", {24'h0, alu_a}, 32'h05);
            check("bp_b", {24'h0, alu_b}, 32'hFF);
            check_reg("bp_rf2_held", 2'd2, 8'h00);
            check("bp_retire", {28'h0, retire_cnt}, 32'd4);
            @(negedge clk);
        end
        alu_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reg("bp_rf2_wb", 2'd2, 8'h05);
        check("bp_retire_wb", {28'h0, retire_cnt}, 32'd5);

        // Dependent pair, rt dependency, and imm masking rt
        issue(2'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h09, st);
        issue(2'h0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, st);
        check("pair_stall", st, exp_dep_stall);
        issue(2'h1, 2'd3, 2'd3, 2'd2, 1'b0, 8'h00, st);
        check("rt_dep_stall", st, exp_dep_stall);
        issue(2'h0, 2'd1, 2'd0, 2'd3, 1'b1, 8'h02, st);
        check("imm_no_stall", st, 0);
        idle(3);
        check_reg("pair_rf2_0a", 2'd2, 8'h0A);
        check_reg("rt_rf3_f5", 2'd3, 8'hF5);
        check_all_regs("dep_rf");

        // Counter wrap with a mixed stream
        for (int i = 0; i < 10; i++) begin
            issue(2'(i), 2'((i % 3) + 1), 2'((i + 1) % 4), 2'((i + 2) % 4), i[0], 8'($urandom_range(0, 255)), st);
        end
        idle(3);
        check("wrap_retire", {28'h0, retire_cnt}, {28'h0, mcnt});
        check("wrap_retire_const", {28'h0, retire_cnt}, 32'd3);
        check_all_regs("wrap_rf");

        // Asynchronous reset with an instruction stalled at the ALU
        alu_ready = 1'b0;
        issue(2'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33, st);
        @(negedge clk);
        in_valid = 1'b0;
        #3 check("pre_rst_valid", {31'h0, alu_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid", {31'h0, alu_valid}, 32'h0);
        check("mid_rst_retire", {28'h0, retire_cnt}, 32'h0);
        check_all_regs("mid_rst_rf");
        @(negedge clk);
        alu_ready = 1'b1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post_rst_retire", {28'h0, retire_cnt}, 32'h0);
        check("post_rst_valid", {31'h0, alu_valid}, 32'h0);
        check_reg("post_rst_rf1", 2'd1, 8'h00);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
